spi_fl_arbiter: RTL and testbench

- Sequencer/arbiter in front of the SPI flash master (spi_master_fl).
- Shares the master between two requesters:
  - Port A: the CPU register front-end. Full command control.
  - Port B: the boot/fetch engine. Fixed-format 32-bit reads.
- Turns the master's level/tready handshake into a clean req/ready, resp pulse protocol per port.
- Adds round-robin arbitration and a hang timeout.

---
 rtl/spi_fl_pkg.sv | 23 ++
 rtl/spi_fl_arbiter_if.sv | 51 +++++
 rtl/spi_fl_rr_arb2.sv | 24 ++
 rtl/spi_fl_arbiter.sv | 173 +++++++++++++++++
 tb/tb_spi_fl_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_fl_pkg.sv
// Shared types and encodings for the SPI flash sequencer/arbiter slice.
package spi_fl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_RESP
  } state_e;

  localparam logic [2:0] CMD_ONLY      = 3'b000;
  localparam logic [2:0] CMD_ANS       = 3'b001;
  localparam logic [2:0] CMD_ADDR_ANS  = 3'b010;
  localparam logic [2:0] CMD_DATA      = 3'b011;
  localparam logic [2:0] CMD_ADDR_DATA = 3'b100;
  localparam logic [2:0] CMD_ADDR      = 3'b101;

  localparam logic [1:0] FRAME_SINGLE = 2'b00;
  localparam logic [1:0] FRAME_DUAL   = 2'b01;
  localparam logic [1:0] FRAME_QUAD   = 2'b10;

endpackage

// File: rtl/spi_fl_arbiter_if.sv
// Requester ports A/B and the spi_master_fl command bus, bundled for the arbiter.
interface spi_fl_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [7:0]  a_command;
  logic [2:0]  a_commtype;
  logic [31:0] a_address;
  logic [31:0] a_wdata;
  logic [6:0]  a_nmiso;
  logic [3:0]  a_dummy;
  logic [7:0]  a_frame;
  logic        a_resp_valid;
  logic [31:0] a_resp_data;
  logic        a_resp_err;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_address;
  logic        b_resp_valid;
  logic [31:0] b_resp_data;
  logic        b_resp_err;
  logic        m_validflag;
  logic [31:0] m_data_in;
  logic [31:0] m_address;
  logic [7:0]  m_command;
  logic [2:0]  m_commtype;
  logic [6:0]  m_nmiso_bits;
  logic [3:0]  m_dummy_cycles;
  logic [7:0]  m_frame_struct;
  logic        m_tready;
  logic [31:0] m_data_out;

  modport master (
    input  a_valid, a_command, a_commtype, a_address, a_wdata, a_nmiso, a_dummy, a_frame,
    output a_ready, a_resp_valid, a_resp_data, a_resp_err,
    input  b_valid, b_address,
    output b_ready, b_resp_valid, b_resp_data, b_resp_err,
    output m_validflag, m_data_in, m_address, m_command, m_commtype,
    output m_nmiso_bits, m_dummy_cycles, m_frame_struct,
    input  m_tready, m_data_out
  );

  modport slave (
    output a_valid, a_command, a_commtype, a_address, a_wdata, a_nmiso, a_dummy, a_frame,
    input  a_ready, a_resp_valid, a_resp_data, a_resp_err,
    output b_valid, b_address,
    input  b_ready, b_resp_valid, b_resp_data, b_resp_err,
    input  m_validflag, m_data_in, m_address, m_command, m_commtype,
    input  m_nmiso_bits, m_dummy_cycles, m_frame_struct,
    output m_tready, m_data_out
  );
endinterface

// File: rtl/spi_fl_rr_arb2.sv
// Two-way round-robin grant; the port served last loses a simultaneous request.
module spi_fl_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic upd_i,
  input  logic last_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);
  logic prio_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_b_q <= 1'b0;
    else if (upd_i) prio_b_q <= ~last_b_i;
  end

  always_comb begin
    gnt_a_o = en_i && req_a_i && (!req_b_i || !prio_b_q);
    gnt_b_o = en_i && req_b_i && (!req_a_i || prio_b_q);
  end
endmodule

// File: rtl/spi_fl_arbiter.sv
// Shares spi_master_fl between the CPU front-end (A) and the boot fetch engine (B),
// converting the master's validflag/tready levels into req/ready and resp pulses.
module spi_fl_arbiter
  import spi_fl_pkg::*;
#(
  parameter logic [7:0] B_COMMAND      = 8'h03,
  parameter logic [2:0] B_COMMTYPE     = 3'b010,
  parameter logic [6:0] B_NMISO        = 7'd32,
  parameter logic [3:0] B_DUMMY        = 4'd0,
  parameter logic [7:0] B_FRAME        = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_W           = 13
) (
  input logic             clk,
  input logic             rst_n,
  spi_fl_arbiter_if.master bus
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic        gnt_b_q;
  logic [TO_W-1:0] to_q;
  logic        a_ready_q, b_ready_q;
  logic        a_resp_valid_q, b_resp_valid_q, a_resp_err_q, b_resp_err_q;
  logic [31:0] a_resp_data_q, b_resp_data_q;
  logic        m_validflag_q;
  logic [31:0] m_data_in_q, m_address_q;
  logic [7:0]  m_command_q, m_frame_q;
  logic [2:0]  m_commtype_q;
  logic [6:0]  m_nmiso_q;
  logic [3:0]  m_dummy_q;
  logic        gnt_a, gnt_b;
  logic        fin;
  logic        fin_err;
  logic [31:0] fin_data;

  spi_fl_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (state_q == ST_IDLE && bus.m_tready),
    .req_a_i (bus.a_valid),
    .req_b_i (bus.b_valid),
    .upd_i   (state_q == ST_RESP),
    .last_b_i(gnt_b_q),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  // A completion (normal or timeout) is decided here so both wait states share one response path.
  always_comb begin
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;
    if (state_q == ST_WAIT_ACK) begin
      if (bus.m_tready && to_q == TO_LAST) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
    end else if (state_q == ST_WAIT_DONE) begin
      if (bus.m_tready) begin
        fin      = 1'b1;
        fin_data = bus.m_data_out;
      end else if (to_q == TO_LAST) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      gnt_b_q        <= 1'b0;
      to_q           <= '0;
      a_ready_q      <= 1'b0;
      b_ready_q      <= 1'b0;
      a_resp_valid_q <= 1'b0;
      b_resp_valid_q <= 1'b0;
      a_resp_err_q   <= 1'b0;
      b_resp_err_q   <= 1'b0;
      a_resp_data_q  <= '0;
      b_resp_data_q  <= '0;
      m_validflag_q  <= 1'b0;
      m_data_in_q    <= '0;
      m_address_q    <= '0;
      m_command_q    <= '0;
      m_commtype_q   <= '1;
      m_nmiso_q      <= '0;
      m_dummy_q      <= '0;
      m_frame_q      <= '0;
    end else begin
      a_ready_q      <= 1'b0;
      b_ready_q      <= 1'b0;
      a_resp_valid_q <= 1'b0;
      b_resp_valid_q <= 1'b0;
      if (fin) begin
        m_validflag_q <= 1'b0;
        state_q       <= ST_RESP;
        if (gnt_b_q) begin
          b_resp_valid_q <= 1'b1;
          b_resp_data_q  <= fin_data;
          b_resp_err_q   <= fin_err;
        end else begin
          a_resp_valid_q <= 1'b1;
          a_resp_data_q  <= fin_data;
          a_resp_err_q   <= fin_err;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (gnt_a || gnt_b) begin
              gnt_b_q <= gnt_b;
              state_q <= ST_ISSUE;
              if (gnt_b) begin
                b_ready_q    <= 1'b1;
                m_command_q  <= B_COMMAND;
                m_commtype_q <= B_COMMTYPE;
                m_address_q  <= bus.b_address;
                m_data_in_q  <= '0;
                m_nmiso_q    <= B_NMISO;
                m_dummy_q    <= B_DUMMY;
                m_frame_q    <= B_FRAME;
              end else begin
                a_ready_q    <= 1'b1;
                m_command_q  <= bus.a_command;
                m_commtype_q <= bus.a_commtype;
                m_address_q  <= bus.a_address;
                m_data_in_q  <= bus.a_wdata;
                m_nmiso_q    <= bus.a_nmiso;
                m_dummy_q    <= bus.a_dummy;
                m_frame_q    <= bus.a_frame;
              end
            end
          end
          ST_ISSUE: begin
            m_validflag_q <= 1'b1;
            to_q          <= '0;
            state_q       <= ST_WAIT_ACK;
          end
          ST_WAIT_ACK: begin
            if (!bus.m_tready) begin
              m_validflag_q <= 1'b0;
              to_q          <= '0;
              state_q       <= ST_WAIT_DONE;
            end else begin
              to_q <= to_q + 1'b1;
            end
          end
          ST_WAIT_DONE: to_q <= to_q + 1'b1;
          ST_RESP:      state_q <= ST_IDLE;
          default:      state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.a_ready        = a_ready_q;
  assign bus.b_ready        = b_ready_q;
  assign bus.a_resp_valid   = a_resp_valid_q;
  assign bus.a_resp_data    = a_resp_data_q;
  assign bus.a_resp_err     = a_resp_err_q;
  assign bus.b_resp_valid   = b_resp_valid_q;
  assign bus.b_resp_data    = b_resp_data_q;
  assign bus.b_resp_err     = b_resp_err_q;
  assign bus.m_validflag    = m_validflag_q;
  assign bus.m_data_in      = m_data_in_q;
  assign bus.m_address      = m_address_q;
  assign bus.m_command      = m_command_q;
  assign bus.m_commtype     = m_commtype_q;
  assign bus.m_nmiso_bits   = m_nmiso_q;
  assign bus.m_dummy_cycles = m_dummy_q;
  assign bus.m_frame_struct = m_frame_q;
endmodule

// File: tb/tb_spi_fl_arbiter.sv
// Directed bench for spi_fl_arbiter with a behavioural spi_master_fl handshake model.
module tb_spi_fl_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  spi_fl_arbiter_if bus();

  spi_fl_arbiter #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_b;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] dq[$];
  int          mode = 0;   // 0 normal master, 1 never drops tready, 2 drops and never raises
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_resp(input bit is_b, input logic [31:0] data, input bit err);
    exp_t e;
    e.is_b = is_b;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
    if (!err) dq.push_back(data);
  endtask

  // Master model: takes a command on validflag, drops tready, returns data 3 cycles later.
  initial begin
    int unsigned cnt = 0;
    bit busy = 1'b0;
    bus.m_tready   = 1'b1;
    bus.m_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.m_tready = 1'b1; bus.m_data_out = '0; busy = 1'b0; cnt = 0;
      end else if (mode == 0) begin
        if (bus.m_tready && bus.m_validflag) begin
          bus.m_tready = 1'b0; cnt = 2; busy = 1'b1;
        end else if (!bus.m_tready) begin
          if (cnt > 0) cnt--;
          else begin
            bus.m_tready = 1'b1;
            bus.m_data_out = (busy && dq.size() > 0) ? dq.pop_front() : 32'h0;
            busy = 1'b0;
          end
        end
      end else if (mode == 2) begin
        if (bus.m_tready && bus.m_validflag) bus.m_tready = 1'b0;
      end
    end
  end

  task automatic check_resp(input bit is_b, input logic [31:0] data, input bit err);
    exp_t e;
    chk("resp_vf_low", bus.m_validflag, 0);
    if (sb.size() == 0) chk("resp_unexpected", 1, 0);
    else begin
      e = sb.pop_front();
      chk("resp_port", is_b, e.is_b);
      chk("resp_data", data, e.data);
      chk("resp_err", err, e.err);
    end
  endtask

  initial begin
    bit pa = 1'b0, pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin pa = 1'b0; pb = 1'b0; continue; end
      if (bus.a_resp_valid) begin
        chk("a_resp_pulse_width", pa, 0);
        check_resp(1'b0, bus.a_resp_data, bus.a_resp_err);
      end
      if (bus.b_resp_valid) begin
        chk("b_resp_pulse_width", pb, 0);
        check_resp(1'b1, bus.b_resp_data, bus.b_resp_err);
      end
      pa = bus.a_resp_valid;
      pb = bus.b_resp_valid;
    end
  end

  task automatic wait_ready(input bit is_b);
    int unsigned n = 0;
    do begin @(negedge clk); n++; end
    while (!(is_b ? bus.b_ready : bus.a_ready) && n < 100);
    chk(is_b ? "b_ready" : "a_ready", is_b ? bus.b_ready : bus.a_ready, 1);
    chk("vf_low_at_grant", bus.m_validflag, 0);
  endtask

  task automatic after_grant(input bit is_b);
    @(negedge clk);
    chk(is_b ? "b_ready_pulse" : "a_ready_pulse", is_b ? bus.b_ready : bus.a_ready, 0);
    chk("vf_high_issue", bus.m_validflag, 1);
  endtask

  task automatic req_a(input logic [7:0] cmd, input logic [2:0] ct, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [6:0] nm);
    bus.a_valid = 1'b1; bus.a_command = cmd; bus.a_commtype = ct; bus.a_address = addr;
    bus.a_wdata = wd; bus.a_nmiso = nm; bus.a_dummy = 4'd0; bus.a_frame = 8'h00;
    wait_ready(1'b0);
    bus.a_valid = 1'b0;
    bus.a_command = 8'hxx;
    after_grant(1'b0);
  endtask

  task automatic req_b(input logic [31:0] addr);
    bus.b_valid = 1'b1; bus.b_address = addr;
    wait_ready(1'b1);
    bus.b_valid = 1'b0;
    after_grant(1'b1);
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk(tag, sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, g;
    bus.a_valid = 1'b1; bus.a_command = 8'h9F; bus.a_commtype = 3'b001;
    bus.a_address = '0; bus.a_wdata = '0; bus.a_nmiso = 7'd24; bus.a_dummy = '0; bus.a_frame = '0;
    bus.b_valid = 1'b1; bus.b_address = 32'h0000_2000;
    repeat (3) @(negedge clk);
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_b_ready", bus.b_ready, 0);
    chk("rst_vf", bus.m_validflag, 0);
    chk("rst_commtype", bus.m_commtype, 3'b111);
    chk("rst_a_resp_valid", bus.a_resp_valid, 0);
    chk("rst_b_resp_data", bus.b_resp_data, 0);

    // Both requesters held from reset: grants must alternate A,B,A,B.
    expect_resp(1'b0, 32'h1111_1111, 1'b0);
    expect_resp(1'b1, 32'h2222_2222, 1'b0);
    expect_resp(1'b0, 32'h3333_3333, 1'b0);
    expect_resp(1'b1, 32'h4444_4444, 1'b0);
    rst_n = 1'b1;
    n = 0; g = 0;
    while (g < 4 && n < 400) begin
      @(negedge clk); n++;
      if (bus.a_ready || bus.b_ready) begin
        chk("alt_vf_low_at_grant", bus.m_validflag, 0);
        g++;
      end
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    chk("alt_grant_count", g, 4);
    wait_drain("alt_drain");

    // Port A JEDEC ID read.
    expect_resp(1'b0, 32'h00C2_2018, 1'b0);
    req_a(8'h9F, 3'b001, 32'h0, 32'h0, 7'd24);
    chk("a_m_command", bus.m_command, 8'h9F);
    chk("a_m_commtype", bus.m_commtype, 3'b001);
    chk("a_m_nmiso", bus.m_nmiso_bits, 7'd24);
    wait_drain("a_drain");

    // Port B fixed-format read.
    expect_resp(1'b1, 32'hDEAD_BEEF, 1'b0);
    req_b(32'h0000_1000);
    chk("b_m_command", bus.m_command, 8'h03);
    chk("b_m_commtype", bus.m_commtype, 3'b010);
    chk("b_m_nmiso", bus.m_nmiso_bits, 7'd32);
    chk("b_m_address", bus.m_address, 32'h0000_1000);
    chk("b_m_data_in", bus.m_data_in, 32'h0);
    chk("b_m_dummy", bus.m_dummy_cycles, 4'd0);
    chk("b_m_frame", bus.m_frame_struct, 8'h00);
    wait_drain("b_drain");

    // Port A write returns the master's (zero) data_out.
    expect_resp(1'b0, 32'h0, 1'b0);
    req_a(8'h02, 3'b100, 32'h0000_0040, 32'hCAFE_F00D, 7'd0);
    chk("w_m_data_in", bus.m_data_in, 32'hCAFE_F00D);
    chk("w_m_address", bus.m_address, 32'h0000_0040);
    wait_drain("w_drain");

    // Master never acknowledges: WAIT_ACK timeout.
    mode = 1;
    expect_resp(1'b0, 32'h0, 1'b1);
    req_a(8'h9F, 3'b001, 32'h0, 32'h0, 7'd24);
    wait_drain("to_ack_drain");
    mode = 0;
    expect_resp(1'b0, 32'h5A5A_0001, 1'b0);
    req_a(8'h0B, 3'b010, 32'h0000_0100, 32'h0, 7'd32);
    wait_drain("to_recover_drain");

    // Master acknowledges but never completes: WAIT_DONE timeout.
    mode = 2;
    expect_resp(1'b1, 32'h0, 1'b1);
    req_b(32'h0000_3000);
    wait_drain("to_done_drain");
    mode = 0;
    repeat (3) @(negedge clk);

    // Reset while parked in WAIT_DONE.
    chk("a_resp_data_hold", bus.a_resp_data, 32'h5A5A_0001);
    mode = 2;
    req_a(8'h9F, 3'b001, 32'h0, 32'h0, 7'd24);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vf", bus.m_validflag, 0);
    chk("mid_rst_commtype", bus.m_commtype, 3'b111);
    chk("mid_rst_command", bus.m_command, 8'h00);
    chk("mid_rst_a_resp_data", bus.a_resp_data, 32'h0);
    chk("mid_rst_b_resp_err", bus.b_resp_err, 0);
    sb.delete();
    dq.delete();
    mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_resp(1'b0, 32'h1357_9BDF, 1'b0);
    req_a(8'h9F, 3'b001, 32'h0, 32'h0, 7'd24);
    wait_drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
